// File: rtl/debug_reg_reader_pkg.sv
// Shared types and seven-segment constants for the register-file debug readout.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is written first, entry 0 last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] segDecode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/debug_reg_reader_if.sv
// Bus between the readout engine, the register file debug port and the HEX pins.
interface debug_reg_reader_if;

    logic        enable;
    logic        auto_mode;
    logic        step;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [4:0]  cur_idx;
    logic        valid;
    logic [55:0] hex_out;

    modport slave (
        input  enable, auto_mode, step, rf_rd_data,
        output rf_rd_addr, cur_idx, valid, hex_out
    );

    modport master (
        output enable, auto_mode, step, rf_rd_data,
        input  rf_rd_addr, cur_idx, valid, hex_out
    );

endinterface

// File: rtl/debug_reg_reader_hex7seg.sv
// One nibble to one active-low seven-segment digit, purely combinational.
module hex7seg
    import debug_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = segDecode(i_nibble);

endmodule

// File: rtl/debug_reg_reader.sv
// Walks the register file through a spare read port and latches each value,
// decoded to eight HEX digits, for a timed or step-driven hold.
module debug_reg_reader
    import debug_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int NUM_REGS    = 32,
    parameter int DATA_W      = 32
)(
    input  logic               clk,
    input  logic               rst,
    debug_reg_reader_if.slave  bus
);

    localparam int             CW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [4:0]     IDX_LAST = 5'(NUM_REGS - 1);

    state_t          r_state;
    state_t          w_nextState;
    logic [4:0]      r_idx;
    logic [55:0]     r_hex;
    logic            r_valid;
    logic [CW-1:0]   r_cnt;
    logic            r_stepQ;

    logic            w_stepRise;
    logic            w_capture;
    logic            w_advance;
    logic            w_countUp;
    logic            w_stop;
    logic [55:0]     w_hex;

    assign w_stepRise = bus.step & ~r_stepQ;

    for (genvar g = 0; g < DATA_W / 4; g++) begin : g_digit
        hex7seg u_hex7seg (
            .i_nibble (bus.rf_rd_data[g*4 +: 4]),
            .o_seg    (w_hex[g*7 +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Dropping enable wins over everything; a step edge wins over the timer,
    // so a coincident expiry and step still yields a single advance.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_countUp   = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.enable) begin
                    w_nextState = SETTLE;
                end
            end
            SETTLE: begin
                if (!bus.enable) begin
                    w_nextState = IDLE;
                    w_stop      = 1'b1;
                end else begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!bus.enable) begin
                    w_nextState = IDLE;
                    w_stop      = 1'b1;
                end else begin
                    w_nextState = HOLD;
                    w_capture   = 1'b1;
                end
            end
            HOLD: begin
                if (!bus.enable) begin
                    w_nextState = IDLE;
                    w_stop      = 1'b1;
                end else if (w_stepRise || (bus.auto_mode && r_cnt == CNT_LAST)) begin
                    w_nextState = SETTLE;
                    w_advance   = 1'b1;
                end else if (bus.auto_mode) begin
                    w_countUp   = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_hex   <= {8{SEG_BLANK}};
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_stepQ <= 1'b0;
        end else begin
            r_stepQ <= bus.step;
            if (w_capture) begin
                r_hex   <= w_hex;
                r_valid <= 1'b1;
                r_cnt   <= '0;
            end
            if (w_advance) begin
                r_idx   <= (r_idx == IDX_LAST) ? 5'd0 : r_idx + 5'd1;
                r_valid <= 1'b0;
            end
            if (w_countUp) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_stop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.rf_rd_addr = r_idx;
    assign bus.cur_idx    = r_idx;
    assign bus.valid      = r_valid;
    assign bus.hex_out    = r_hex;

endmodule
